// File: rtl/hazard_unit.sv
// Pipeline hazard control: latch enables/flushes and PC enable for the 5-stage pipe,
// with a RUN/MEMWAIT/HALT FSM and saturating stall/flush cycle counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             mem_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;
  state_t state, next_state;

  logic ld_use, dwait, stall_inc;

  assign ld_use = ex_memread && (ex_wsel != 5'd0) &&
                  ((ex_wsel == id_rs) || (ex_wsel == id_rt));
  assign dwait  = mem_req && !dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    case (state)
      HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: begin
        if (mem_halt) begin
          // Let the HALT itself retire into MEM/WB, freeze everything upstream.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          next_state = HALT;
        end else if (dwait) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          memwb_en   = 1'b0;
          next_state = MEMWAIT;
        end else begin
          next_state = RUN;
          if (ex_taken) begin
            // Squashing IF/ID also cancels any load-use against it.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ld_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
    endcase
  end

  assign halted    = (state == HALT);
  assign stall_inc = !pc_en && (state != HALT) && !mem_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && !(&stall_count))  stall_count <= stall_count + CNT_W'(1);
      if (idex_flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; control vector order is
// {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}.
module tb_hazard_unit;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_req, mem_halt, ex_memread, ex_taken;
  logic [4:0]       ex_wsel, id_rs, id_rt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [6:0]       ctrl;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .mem_halt(mem_halt), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt), .ex_taken(ex_taken), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  localparam logic [6:0] C_RUN   = 7'b1101011;
  localparam logic [6:0] C_LDUSE = 7'b0001111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_TAKEN = 7'b1111111;
  localparam logic [6:0] C_IMISS = 7'b0111011;
  localparam logic [6:0] C_HALT1 = 7'b0000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; mem_halt = 1'b0;
    ex_memread = 1'b0; ex_taken = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  // Advance one edge; inputs are changed and outputs sampled well clear of it.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    nRST = 1'b1;
    tick();

    // load-use bubble
    ex_memread = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; #1;
    chk("lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    idle(); #1;
    chk("lduse_after", 32'(ctrl), 32'(C_RUN));
    chk("lduse_stall", 32'(stall_count), 32'd1);
    chk("lduse_flush", 32'(flush_count), 32'd1);

    // load to $0 never stalls
    ex_memread = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
    chk("ld_r0_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    idle(); #1;
    chk("ld_r0_stall", 32'(stall_count), 32'd1);
    chk("ld_r0_flush", 32'(flush_count), 32'd1);

    // data wait for 3 cycles
    mem_req = 1'b1; dhit = 1'b0; #1;
    chk("dwait0", 32'(ctrl), 32'(C_FRZ));
    tick(); #1;
    chk("dwait1", 32'(ctrl), 32'(C_FRZ));
    tick(); #1;
    chk("dwait2", 32'(ctrl), 32'(C_FRZ));
    tick();
    dhit = 1'b1; #1;
    chk("dwait_done", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("dwait_stall", 32'(stall_count), 32'd4);
    mem_req = 1'b1; dhit = 1'b1; #1;
    chk("dhit_same_cycle", 32'(ctrl), 32'(C_RUN));
    tick();
    idle(); #1;
    chk("run_after_wait", 32'(ctrl), 32'(C_RUN));
    chk("dhit_no_stall", 32'(stall_count), 32'd4);

    // taken branch masks a simultaneous load-use
    ex_taken = 1'b1; ex_memread = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; #1;
    chk("taken_ctrl", 32'(ctrl), 32'(C_TAKEN));
    tick();
    idle(); #1;
    chk("taken_stall", 32'(stall_count), 32'd4);
    chk("taken_flush", 32'(flush_count), 32'd2);

    // instruction miss, alone and with a load-use on rt
    ihit = 1'b0; #1;
    chk("imiss_ctrl", 32'(ctrl), 32'(C_IMISS));
    tick();
    ex_memread = 1'b1; ex_wsel = 5'd3; id_rt = 5'd3; #1;
    chk("imiss_lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    idle(); #1;
    chk("imiss_stall", 32'(stall_count), 32'd6);
    chk("imiss_flush", 32'(flush_count), 32'd3);

    // halt: one drain cycle, then frozen regardless of inputs
    mem_halt = 1'b1; #1;
    chk("halt_entry_ctrl", 32'(ctrl), 32'(C_HALT1));
    chk("halt_entry_flag", 32'(halted), 32'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      mem_halt = i[0]; ihit = i[1]; ex_taken = i[0]; mem_req = i[2]; dhit = i[1];
      ex_memread = 1'b1; ex_wsel = 5'd7; id_rs = 5'd7; #1;
      chk($sformatf("halt_ctrl_%0d", i), 32'(ctrl), 32'(C_FRZ));
      chk($sformatf("halt_flag_%0d", i), 32'(halted), 32'd1);
      tick();
    end
    chk("halt_stall", 32'(stall_count), 32'd6);
    chk("halt_flush", 32'(flush_count), 32'd3);
    #1 nRST = 1'b0;
    #1;
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_stall", 32'(stall_count), 32'd0);
    chk("async_flush", 32'(flush_count), 32'd0);
    idle(); #1;
    chk("async_ctrl", 32'(ctrl), 32'(C_RUN));
    nRST = 1'b1;
    tick();

    // stall counter saturation
    ihit = 1'b0;
    repeat (65534) @(posedge CLK);
    #2;
    chk("sat_fffe", 32'(stall_count), 32'h0000FFFE);
    tick();
    chk("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    repeat (6) @(posedge CLK);
    #2;
    chk("sat_hold", 32'(stall_count), 32'h0000FFFF);
    chk("sat_flush", 32'(flush_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that works alongside the forwarding unit. The forwarding unit consumes producer info to select bypass paths; this block handles the cases forwarding cannot cover.
- It generates per-latch enable and flush controls for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Covered cases: load-use hazards, taken branch/jump redirects, instruction/data memory wait, and halt.
- A small registered FSM tracks memory-wait and sticky halt. Saturating counters record stall and flush cycles for performance reporting.

Parameters:
CNT_W, 16, width of stall_count and flush_count.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
mem_req  in  1  EX/MEM instruction is a load or store (dREN|dWEN)
mem_halt  in  1  EX/MEM instruction is HALT
ex_memread  in  1  ID/EX instruction is a load
ex_wsel  in  5  ID/EX destination register
id_rs  in  5  IF/ID rs field
id_rt  in  5  IF/ID rt field
ex_taken  in  1  EX resolves a taken branch, or a jump (J/JAL/JR)
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID load bubble
idex_en  out  1  ID/EX latch enable
idex_flush  out  1  ID/EX load bubble
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
halted  out  1  sticky halt indication
stall_count  out  CNT_W  cycles with pc_en=0 while not halted
flush_count  out  CNT_W  cycles with idex_flush=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (CLK, nRST).
- States: RUN, MEMWAIT, HALT. The state register is reset asynchronously to RUN. halted, stall_count and flush_count reset to 0.
- Control outputs are combinational from state plus inputs. Default in RUN with no hazard: all *_en=1, all *_flush=0.
- HALT state:
  - all *_en=0, flushes=0, halted=1.
  - Stays in HALT until nRST; all other inputs are ignored.
- RUN → HALT when mem_halt=1. In that same cycle: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1 so HALT reaches WB.
- Priority in RUN and MEMWAIT, highest first: mem_halt, data wait, ex_taken, load-use, ihit miss.
- Data wait: mem_req=1 and dhit=0.
  - All *_en=0, flushes=0.
  - Next state is MEMWAIT.
  - Remain in MEMWAIT while dhit=0.
  - The cycle with dhit=1 gives full advance (all en=1); next state is RUN.
  - Entering data wait with dhit=1 in the same cycle is not a wait: RUN decode applies.
- ex_taken=1:
  - pc_en=1 (PC loads target), ifid_flush=1, idex_flush=1.
  - ifid_en and idex_en remain 1.
  - A simultaneous load-use is suppressed, because its IF/ID instruction is being squashed.
- Load-use: ex_memread=1 and ex_wsel≠0 and (ex_wsel==id_rs or ex_wsel==id_rt).
  - pc_en=0, ifid_en=0, idex_flush=1; exmem_en and memwb_en = 1.
  - Exactly one bubble. The next cycle the load is in EX/MEM, and forwarding covers it.
- ihit=0 (no higher-priority condition):
  - pc_en=0, ifid_flush=1 (bubble into decode); downstream latches advance.
  - If load-use is also active, load-use controls take precedence for ifid_en, with ifid_flush=0.
- When any latch has flush=1 and en=1, the latch loads zeros, i.e. a NOP.
- Counters:
  - stall_count increments on every rising edge where pc_en=0 and state≠HALT and mem_halt=0.
  - flush_count increments when idex_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-MEMWAIT or mid-HALT returns immediately to RUN; counters clear; halted drops asynchronously.

Test Plan:
1. Load-use: ex_memread=1, ex_wsel=8, id_rs=8, ihit=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_count=1, flush_count=1.
2. Load to $0: ex_memread=1, ex_wsel=0, id_rt=0 → no stall, all en=1, counters unchanged.
3. Data wait: mem_req=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with all en=0, then 1 cycle with all en=1; stall_count=3; state RUN after.
4. Branch plus load-use same cycle: ex_taken=1, ex_memread=1, ex_wsel=id_rs=5 → pc_en=1, ifid_flush=1, idex_flush=1; no stall; flush_count +1.
5. Halt: mem_halt=1 → memwb_en=1, others 0 that cycle; then halted=1 with all en=0 for 10+ cycles regardless of inputs; nRST low → halted=0 asynchronously, counters 0.
6. Saturation: force 2^16+5 ihit=0 cycles → stall_count holds at 16'hFFFF.
